// File: rtl/cdb_arbiter_pkg.sv
// cdb_arbiter_pkg: shared Tomasulo CDB sizing and requester index constants
package cdb_arbiter_pkg;
  localparam int CDB_NUM_REQ = 4;
  localparam int PID_WIDTH = 6;
  localparam int PRF_DEPTH = 48;
  localparam int DATA_WIDTH = 32;
  localparam int ROB_TAG_WIDTH = 5;
  localparam int REQ_INT = 0;
  localparam int REQ_MUL = 1;
  localparam int REQ_DIV = 2;
  localparam int REQ_LS = 3;
endpackage

// File: rtl/cdb_arbiter_rr_arbiter.sv
// rr_arbiter: round-robin pick of the first set request at or after rr_ptr
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   rr_ptr,
  input  logic               enable,
  output logic [NUM_REQ-1:0] grant,
  output logic [PTR_W-1:0]   idx
);
  // scan from the farthest offset down so the nearest valid requester wins
  always_comb begin
    grant = '0;
    idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (enable && req[(int'(rr_ptr) + k) % NUM_REQ]) begin
        grant = NUM_REQ'(1) << ((int'(rr_ptr) + k) % NUM_REQ);
        idx = PTR_W'((int'(rr_ptr) + k) % NUM_REQ);
      end
    end
  end
endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin CDB arbitration with a registered broadcast that
// also drives the ready-bit array write port
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_REQ = CDB_NUM_REQ,
  parameter int PID_WIDTH = cdb_arbiter_pkg::PID_WIDTH,
  parameter int DATA_WIDTH = cdb_arbiter_pkg::DATA_WIDTH,
  parameter int ROB_TAG_WIDTH = cdb_arbiter_pkg::ROB_TAG_WIDTH
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             flush,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ*PID_WIDTH-1:0]     req_pid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data,
  input  logic [NUM_REQ*ROB_TAG_WIDTH-1:0] req_rob_tag,
  output logic [NUM_REQ-1:0]               req_grant,
  output logic                             cdb_valid,
  output logic [PID_WIDTH-1:0]             cdb_pid,
  output logic [DATA_WIDTH-1:0]            cdb_data,
  output logic [ROB_TAG_WIDTH-1:0]         cdb_rob_tag,
  output logic                             rba_w_en,
  output logic [PID_WIDTH-1:0]             rba_w_addr,
  output logic                             rba_din
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  logic [PTR_W-1:0] rr_ptr, win;
  logic xfer;
  rr_arbiter #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_rr (
    .req(req_valid),
    .rr_ptr(rr_ptr),
    .enable(!reset && !flush),
    .grant(req_grant),
    .idx(win)
  );
  assign xfer = |req_grant;
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= '0;
      cdb_valid <= 1'b0;
      cdb_pid <= '0;
      cdb_data <= '0;
      cdb_rob_tag <= '0;
    end else begin
      cdb_valid <= xfer;
      if (xfer) begin
        rr_ptr <= (int'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;
        cdb_pid <= req_pid[win*PID_WIDTH +: PID_WIDTH];
        cdb_data <= req_data[win*DATA_WIDTH +: DATA_WIDTH];
        cdb_rob_tag <= req_rob_tag[win*ROB_TAG_WIDTH +: ROB_TAG_WIDTH];
      end
    end
  end
  assign rba_w_en = cdb_valid;
  assign rba_w_addr = cdb_pid;
  assign rba_din = 1'b1;
endmodule
